prog_imem_ctrl: RTL and testbench
=================================

Name: prog_imem_ctrl

Overview:
Loadable, parametrised instruction memory with a registered fetch port. It replaces the fixed-content combinational instruction ROM in the fetch stage. A program is streamed in over a valid/ready load port at run time. Fetch has one-cycle latency, stall (hold) support and out-of-program address flagging. After reset the memory self-clears to NOP.

Parameters:
IW, 9, instruction width in bits
AW, 7, fetch/load address width
DEPTH, 128, number of instruction words; legal range 2..2**AW
NOP, 0, IW-bit value used for clearing and for invalid fetch output

Ports:
Clk  input  1  system clock, rising edge
Reset_n  input  1  asynchronous, active-low reset
LoadStart  input  1  1-cycle pulse; begins a program load (honoured only in RUN)
LoadData  input  IW  instruction word to write
LoadValid  input  1  LoadData valid
LoadLast  input  1  qualifies the final word of the program (sampled with LoadValid)
LoadReady  output  1  controller accepts a word this cycle
LoadDone  output  1  1-cycle pulse after the final word is written
ProgLen  output  AW+1  number of words in the current program
FetchEn  input  1  1 = fetch FetchAddr this cycle; 0 = stall and hold InstOut
FetchAddr  input  AW  instruction address (program counter)
InstOut  output  IW  registered instruction
InstValid  output  1  InstOut holds a valid program word
AddrErr  output  1  registered; last fetch had FetchAddr >= ProgLen
Busy  output  1  high in CLEAR or LOAD

Behaviour:
- Reset values, asynchronous on Reset_n low:
  - state = CLEAR, clear pointer = 0, ProgLen = 0.
  - InstOut = NOP; InstValid, AddrErr, LoadReady, LoadDone = 0; Busy = 1.
- Reset asserted mid-load or mid-clear aborts the operation. The partially written program is discarded and CLEAR restarts after Reset_n deasserts.
- States:
  - CLEAR: writes NOP to address ptr each cycle, ptr++. On ptr == DEPTH-1 write, go to RUN. Takes exactly DEPTH cycles. LoadStart is ignored.
  - RUN:
    - Fetch is active.
    - LoadStart=1 → LOAD with wptr = 0, ProgLen = 0; InstValid drops to 0 on the next edge.
  - LOAD:
    - LoadReady = 1.
    - Each LoadValid & LoadReady cycle: mem[wptr] = LoadData, wptr++, ProgLen = wptr+1.
    - Exit to RUN on the write where LoadLast = 1, or on the write to DEPTH-1, whichever comes first. LoadReady = 0 from the next cycle.
    - LoadDone pulses in the first RUN cycle.
    - Words beyond the new ProgLen keep their old contents but are unreachable (see AddrErr).
    - LoadStart during LOAD is ignored.
- Fetch, RUN only, 1-cycle latency: FetchEn=1 at edge N → at N+1:
  - If FetchAddr < ProgLen: InstOut = mem[FetchAddr], InstValid = 1, AddrErr = 0.
  - Else: InstOut = NOP, InstValid = 0, AddrErr = 1.
- FetchEn=0: InstOut, InstValid and AddrErr hold their values (stall).
- In CLEAR or LOAD, a fetch with FetchEn=1 yields InstOut = NOP, InstValid = 0, AddrErr = 0. FetchEn=0 still holds.
- Memory has a single write port and a registered read port. Load writes and fetch reads never occur in the same state, so there is no read/write collision.
- ProgLen saturates at DEPTH; width AW+1 allows ProgLen = DEPTH = 2**AW.
- LoadStart and a fetch in the same RUN cycle: the fetch completes normally, then the controller enters LOAD.

Test Plan:
- Reset, then idle: Busy = 1 for exactly 128 cycles, then 0. Fetch addr 0 → InstOut = 0x000, InstValid = 0, AddrErr = 1 (ProgLen = 0).
- Load 4 words 0x104, 0x008, 0x105, 0x010 with LoadLast on the 4th, LoadValid held high → LoadDone pulses once, ProgLen = 4. Fetch addrs 0..3 back-to-back → InstOut sequence 0x104, 0x008, 0x105, 0x010 each 1 cycle after request, InstValid = 1.
- After that load, fetch addr 4 → InstOut = 0x000, InstValid = 0, AddrErr = 1. Fetch addr 2 next → 0x105, AddrErr = 0.
- Stall: fetch addr 1 then FetchEn = 0 for 3 cycles with FetchAddr changed to 3 → InstOut stays 0x008 throughout.
- Load with gaps (LoadValid toggling) and no LoadLast for 128 words → exits on the 128th write, ProgLen = 128. Fetch addr 127 returns the 128th word.
- Reset_n pulsed low during a load after 2 of 4 words → outputs reset immediately; CLEAR runs 128 cycles; ProgLen = 0; all fetches return NOP with AddrErr = 1.

Source files
------------

// File: rtl/prog_imem_ctrl.sv
// rtl/prog_imem_ctrl.sv - loadable instruction memory with registered fetch port
module prog_imem_ctrl #(
    parameter int               IW    = 9,
    parameter int               AW    = 7,
    parameter int               DEPTH = 128,
    parameter logic [IW-1:0]    NOP   = '0
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            LoadStart,
    input  logic [IW-1:0]   LoadData,
    input  logic            LoadValid,
    input  logic            LoadLast,
    output logic            LoadReady,
    output logic            LoadDone,
    output logic [AW:0]     ProgLen,
    input  logic            FetchEn,
    input  logic [AW-1:0]   FetchAddr,
    output logic [IW-1:0]   InstOut,
    output logic            InstValid,
    output logic            AddrErr,
    output logic            Busy
);

    typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_LOAD} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t          state, state_nxt;
    logic [AW-1:0]   ptr;
    logic            load_wr;
    logic            mem_we;
    logic [IW-1:0]   mem_wdata;
    logic            fetch_in_range;
    logic [IW-1:0]   mem [DEPTH];

    // The clear pointer and the load write pointer are never live at the same time, so they share ptr.
    assign load_wr        = (state == ST_LOAD) && LoadValid;
    assign mem_we         = (state == ST_CLEAR) || load_wr;
    assign mem_wdata      = (state == ST_CLEAR) ? NOP : LoadData;
    assign fetch_in_range = ({1'b0, FetchAddr} < ProgLen);
    assign LoadReady      = (state == ST_LOAD);
    assign Busy           = (state != ST_RUN);

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= ST_CLEAR;
        else          state <= state_nxt;
    end

    // Next-state: clear sweep, load trigger, and load termination on LoadLast or a full memory.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (ptr == LAST_ADDR) state_nxt = ST_RUN;
            ST_RUN:   if (LoadStart)        state_nxt = ST_LOAD;
            ST_LOAD:  if (load_wr && (LoadLast || (ptr == LAST_ADDR))) state_nxt = ST_RUN;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    // Single write port shared by the clear sweep and program load.
    always_ff @(posedge Clk) begin
        if (mem_we) mem[ptr] <= mem_wdata;
    end

    // Pointer, program length and load-complete pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr      <= '0;
            ProgLen  <= '0;
            LoadDone <= 1'b0;
        end else begin
            LoadDone <= (state == ST_LOAD) && (state_nxt == ST_RUN);
            case (state)
                ST_CLEAR: ptr <= (ptr == LAST_ADDR) ? '0 : ptr + AW'(1);
                ST_RUN: begin
                    if (LoadStart) begin
                        ptr     <= '0;
                        ProgLen <= '0;
                    end
                end
                ST_LOAD: begin
                    if (load_wr) begin
                        ptr     <= ptr + AW'(1);
                        ProgLen <= {1'b0, ptr} + (AW+1)'(1);
                    end
                end
                default: ptr <= '0;
            endcase
        end
    end

    // Registered fetch; a fetch issued alongside LoadStart completes before the load takes over.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            InstOut   <= NOP;
            InstValid <= 1'b0;
            AddrErr   <= 1'b0;
        end else if (FetchEn) begin
            if (state != ST_RUN) begin
                InstOut   <= NOP;
                InstValid <= 1'b0;
                AddrErr   <= 1'b0;
            end else if (fetch_in_range) begin
                InstOut   <= mem[FetchAddr];
                InstValid <= 1'b1;
                AddrErr   <= 1'b0;
            end else begin
                InstOut   <= NOP;
                InstValid <= 1'b0;
                AddrErr   <= 1'b1;
            end
        end else if ((state == ST_RUN) && LoadStart) begin
            InstValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_imem_ctrl.sv
// tb/tb_prog_imem_ctrl.sv - scoreboard bench for prog_imem_ctrl
module tb_prog_imem_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        LoadStart;
    logic [8:0]  LoadData;
    logic        LoadValid;
    logic        LoadLast;
    logic        LoadReady;
    logic        LoadDone;
    logic [7:0]  ProgLen;
    logic        FetchEn;
    logic [6:0]  FetchAddr;
    logic [8:0]  InstOut;
    logic        InstValid;
    logic        AddrErr;
    logic        Busy;

    typedef struct {
        logic [8:0] inst;
        logic       vld;
        logic       err;
    } exp_t;

    exp_t        sb[$];
    exp_t        last_exp;
    exp_t        mon_e;
    logic [8:0]  model_mem [128];
    logic [8:0]  ld_words [128];
    int          model_len;
    int          n_checks;
    int          n_errors;
    logic        fe_q;
    logic        hold_chk;

    prog_imem_ctrl dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .LoadStart (LoadStart),
        .LoadData  (LoadData),
        .LoadValid (LoadValid),
        .LoadLast  (LoadLast),
        .LoadReady (LoadReady),
        .LoadDone  (LoadDone),
        .ProgLen   (ProgLen),
        .FetchEn   (FetchEn),
        .FetchAddr (FetchAddr),
        .InstOut   (InstOut),
        .InstValid (InstValid),
        .AddrErr   (AddrErr),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) fe_q <= 1'b0;
        else          fe_q <= FetchEn;
    end

    always @(negedge Clk) begin
        if (Reset_n && fe_q) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("fetch_inst", 32'(InstOut), 32'(mon_e.inst));
                check_eq("fetch_valid", 32'(InstValid), 32'(mon_e.vld));
                check_eq("fetch_err", 32'(AddrErr), 32'(mon_e.err));
                last_exp = mon_e;
            end
        end else if (Reset_n && hold_chk) begin
            check_eq("stall_inst", 32'(InstOut), 32'(last_exp.inst));
            check_eq("stall_valid", 32'(InstValid), 32'(last_exp.vld));
        end
    end

    task automatic fetch(input logic [6:0] a);
        exp_t e;
        if (int'(a) < model_len) e = '{inst: model_mem[a], vld: 1'b1, err: 1'b0};
        else                     e = '{inst: 9'h000, vld: 1'b0, err: 1'b1};
        sb.push_back(e);
        FetchEn   = 1'b1;
        FetchAddr = a;
        @(negedge Clk);
    endtask

    task automatic idle(input int n);
        FetchEn = 1'b0;
        repeat (n) @(negedge Clk);
    endtask

    task automatic wait_clear();
        int cnt = 0;
        while (Busy && cnt < 1000) begin
            cnt++;
            @(negedge Clk);
        end
        check_eq("clear_cycles", 32'(cnt), 32'd128);
    endtask

    task automatic load_prog(input int n, input bit use_last, input bit gaps, input int abort_after);
        LoadStart = 1'b1;
        @(negedge Clk);
        LoadStart = 1'b0;
        check_eq("load_ready_on", 32'(LoadReady), 32'd1);
        check_eq("load_busy", 32'(Busy), 32'd1);
        model_len = 0;
        for (int i = 0; i < n; i++) begin
            if (abort_after >= 0 && i == abort_after) return;
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                LoadValid = 1'b0;
                @(negedge Clk);
            end
            LoadData  = ld_words[i];
            LoadValid = 1'b1;
            LoadLast  = use_last && (i == n - 1);
            @(negedge Clk);
            model_mem[i] = ld_words[i];
            model_len    = i + 1;
        end
        LoadValid = 1'b0;
        LoadLast  = 1'b0;
        check_eq("load_done_pulse", 32'(LoadDone), 32'd1);
        check_eq("load_ready_off", 32'(LoadReady), 32'd0);
        check_eq("prog_len", 32'(ProgLen), 32'(n));
        @(negedge Clk);
        check_eq("load_done_low", 32'(LoadDone), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        model_len = 0;
        hold_chk  = 1'b0;
        Reset_n   = 1'b0;
        LoadStart = 1'b0;
        LoadData  = '0;
        LoadValid = 1'b0;
        LoadLast  = 1'b0;
        FetchEn   = 1'b0;
        FetchAddr = '0;
        repeat (3) @(negedge Clk);

        check_eq("rst_inst", 32'(InstOut), 32'h000);
        check_eq("rst_valid", 32'(InstValid), 32'd0);
        check_eq("rst_err", 32'(AddrErr), 32'd0);
        check_eq("rst_ready", 32'(LoadReady), 32'd0);
        check_eq("rst_done", 32'(LoadDone), 32'd0);
        check_eq("rst_busy", 32'(Busy), 32'd1);
        check_eq("rst_len", 32'(ProgLen), 32'd0);

        Reset_n = 1'b1;
        wait_clear();
        fetch(7'd0);
        idle(1);

        ld_words[0] = 9'h104;
        ld_words[1] = 9'h008;
        ld_words[2] = 9'h105;
        ld_words[3] = 9'h010;
        load_prog(4, 1'b1, 1'b0, -1);
        for (int a = 0; a < 4; a++) fetch(7'(a));
        fetch(7'd4);
        fetch(7'd2);
        idle(1);

        fetch(7'd1);
        hold_chk  = 1'b1;
        FetchEn   = 1'b0;
        FetchAddr = 7'd3;
        repeat (3) @(negedge Clk);
        hold_chk  = 1'b0;
        check_eq("stall_end_inst", 32'(InstOut), 32'h008);

        for (int i = 0; i < 128; i++) ld_words[i] = 9'($urandom_range(0, 511));
        ld_words[127] = 9'h1A5;
        load_prog(128, 1'b0, 1'b1, -1);
        fetch(7'd127);
        fetch(7'd0);
        fetch(7'd64);
        fetch(7'd127);
        idle(1);

        for (int i = 0; i < 4; i++) ld_words[i] = 9'(9'h0F0 + i);
        load_prog(4, 1'b1, 1'b0, 2);
        Reset_n = 1'b0;
        #1;
        check_eq("abort_inst", 32'(InstOut), 32'h000);
        check_eq("abort_valid", 32'(InstValid), 32'd0);
        check_eq("abort_ready", 32'(LoadReady), 32'd0);
        check_eq("abort_busy", 32'(Busy), 32'd1);
        check_eq("abort_len", 32'(ProgLen), 32'd0);
        sb.delete();
        model_len = 0;
        @(negedge Clk);
        Reset_n = 1'b1;
        wait_clear();
        check_eq("post_abort_len", 32'(ProgLen), 32'd0);
        fetch(7'd0);
        fetch(7'd1);
        fetch(7'd3);
        idle(2);

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
